data_memory_be: RTL and testbench

DATA_MEMORY_BE -- requirements
Module: data_memory_be

---
 rtl/data_memory_be.sv | 123 ++++++++++++
 tb/tb_data_memory_be.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_be.sv
// Byte-enabled data memory with power-up segment-table initialisation.
// Ports: clk, reset (async, active-high); Address/Write_data/MemRead/MemWrite/
//        MemSize/MemSigned request in; Read_data (comb load), Busy (init sweep), AddrError (comb fault).
module data_memory_be #(
  parameter int RAM_SIZE     = 256,
  parameter int RAM_SIZE_BIT = 8,
  parameter int INIT_WORDS   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  output logic [31:0] Read_data,
  output logic        Busy,
  output logic        AddrError
);

  typedef enum logic {INIT, READY} state_t;

  localparam logic [RAM_SIZE_BIT-1:0] LAST_IDX = RAM_SIZE_BIT'(RAM_SIZE - 1);

  state_t                  state;
  logic [RAM_SIZE_BIT-1:0] init_cnt;
  logic [31:0]             mem [RAM_SIZE];

  logic [RAM_SIZE_BIT-1:0] word_idx;
  logic [1:0]              byte_off;
  logic [31:0]             high_bits;
  logic                    misalign;
  logic [31:0]             cur_word;
  logic [7:0]              byte_val;
  logic [15:0]             half_val;
  logic [31:0]             st_word;
  logic [31:0]             init_val;
  logic                    store_en;

  // Seven-segment patterns for hex digits 0..F.
  function automatic logic [31:0] seg_entry(input logic [3:0] i);
    logic [7:0] v;
    case (i)
      4'h0: v = 8'h3F; 4'h1: v = 8'h06; 4'h2: v = 8'h5B; 4'h3: v = 8'h4F;
      4'h4: v = 8'h66; 4'h5: v = 8'h6D; 4'h6: v = 8'h7D; 4'h7: v = 8'h07;
      4'h8: v = 8'h7F; 4'h9: v = 8'h6F; 4'hA: v = 8'h77; 4'hB: v = 8'h7C;
      4'hC: v = 8'h39; 4'hD: v = 8'h5E; 4'hE: v = 8'h79; default: v = 8'h71;
    endcase
    return {24'h0, v};
  endfunction

  assign word_idx  = Address[RAM_SIZE_BIT+1:2];
  assign byte_off  = Address[1:0];
  // Anything above the word-index field must be zero, otherwise the access
  // would silently alias onto a lower word.
  assign high_bits = Address >> (RAM_SIZE_BIT + 2);
  assign Busy      = (state == INIT);

  always_comb begin
    misalign = 1'b0;
    case (MemSize)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = Address[0];
      2'b10:   misalign = |Address[1:0];
      default: misalign = 1'b1;
    endcase
  end

  assign AddrError = (MemRead | MemWrite) & (misalign | (|high_bits));

  assign cur_word = mem[word_idx];
  assign byte_val = cur_word[{byte_off, 3'b000} +: 8];
  assign half_val = cur_word[{Address[1], 4'b0000} +: 16];

  always_comb begin
    Read_data = 32'h0;
    if (MemRead && (state == READY) && !AddrError) begin
      case (MemSize)
        2'b00:   Read_data = MemSigned ? {{24{byte_val[7]}}, byte_val} : {24'h0, byte_val};
        2'b01:   Read_data = MemSigned ? {{16{half_val[15]}}, half_val} : {16'h0, half_val};
        2'b10:   Read_data = cur_word;
        default: Read_data = 32'h0;
      endcase
    end
  end

  // Read-modify-write merge: only the addressed lane(s) take new data.
  always_comb begin
    st_word = cur_word;
    case (MemSize)
      2'b00:   st_word[{byte_off, 3'b000} +: 8]     = Write_data[7:0];
      2'b01:   st_word[{Address[1], 4'b0000} +: 16] = Write_data[15:0];
      2'b10:   st_word = Write_data;
      default: st_word = cur_word;
    endcase
  end

  assign store_en = (state == READY) && MemWrite && !AddrError;
  assign init_val = (32'(init_cnt) < INIT_WORDS) ? seg_entry(init_cnt[3:0]) : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == LAST_IDX) state <= READY;
    end
  end

  // Array has no reset; the sweep rewrites every word after each reset.
  // Holding off the sweep write while reset is high keeps index 0 from being
  // written repeatedly during a long reset pulse.
  always_ff @(posedge clk) begin
    if ((state == INIT) && !reset) begin
      mem[init_cnt] <= init_val;
    end else if (store_en) begin
      mem[word_idx] <= st_word;
    end
  end

endmodule

// File: tb/tb_data_memory_be.sv
module tb_data_memory_be;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemSize;
  logic        MemSigned;
  logic [31:0] Read_data;
  logic        Busy;
  logic        AddrError;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_edges;

  data_memory_be dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .Write_data(Write_data),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .MemSize   (MemSize),
    .MemSigned (MemSigned),
    .Read_data (Read_data),
    .Busy      (Busy),
    .AddrError (AddrError)
  );

  always #5 clk = ~clk;

  task automatic set_bus(input logic rd, input logic wr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] data);
    MemRead    = rd;
    MemWrite   = wr;
    MemSize    = size;
    MemSigned  = sgn;
    Address    = addr;
    Write_data = data;
  endtask

  task automatic idle();
    set_bus(1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic compare(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %08h expected <queued value>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %08h expected %08h", t, obs, e);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    expect_val(tag, exp);
    compare(obs);
  endtask

  task automatic load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                      input logic sgn, input logic [31:0] exp);
    @(negedge clk);
    set_bus(1'b1, 1'b0, size, sgn, addr, 32'h0);
    expect_val(tag, exp);
    #1 compare(Read_data);
  endtask

  task automatic store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
    @(negedge clk);
    set_bus(1'b0, 1'b1, size, 1'b0, addr, data);
    @(posedge clk);
    #1 idle();
  endtask

  // Faulting store with a simultaneous load of the same address.
  task automatic fault_store(input string tag, input logic [31:0] addr, input logic [1:0] size);
    @(negedge clk);
    set_bus(1'b1, 1'b1, size, 1'b0, addr, 32'hFFFF_FFFF);
    #1;
    chk({tag, "_addrerr"}, {31'h0, AddrError}, 32'h1);
    chk({tag, "_rdata"}, Read_data, 32'h0);
    @(posedge clk);
    #1 idle();
  endtask

  // Counts posedges until Busy drops, bounded so a stuck FSM still ends the run.
  task automatic sweep(input bit mid_chk, output int n);
    n = 0;
    while (Busy === 1'b1 && n < 1000) begin
      @(posedge clk);
      n++;
      #1;
      if (mid_chk && n == 50) begin
        chk("init_store_rdata", Read_data, 32'h0);
        chk("init_store_busy", {31'h0, Busy}, 32'h1);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);

    // Reset state; AddrError is live even while reset/INIT.
    set_bus(1'b1, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rst_busy", {31'h0, Busy}, 32'h1);
    chk("rst_rdata", Read_data, 32'h0);
    set_bus(1'b0, 1'b1, SZ_W, 1'b0, 32'h82, 32'h0);
    #1 chk("rst_addrerr", {31'h0, AddrError}, 32'h1);
    set_bus(1'b0, 1'b0, SZ_W, 1'b0, 32'h82, 32'h0);
    #1 chk("noreq_addrerr", {31'h0, AddrError}, 32'h0);

    // Sweep with a word store to 0x20 held across the whole INIT period.
    @(negedge clk);
    reset = 1'b0;
    set_bus(1'b1, 1'b1, SZ_W, 1'b0, 32'h20, 32'hDEAD_BEEF);
    sweep(1'b1, n_edges);
    idle();
    chk("sweep_len", n_edges, 32'd256);

    // Table contents: words 0, 8 (0x20) and 15 (0x3C); word 16 is zero.
    load("ld_w_0x00", 32'h00, SZ_W, 1'b0, 32'h0000_003F);
    load("ld_w_0x3C", 32'h3C, SZ_W, 1'b0, 32'h0000_0071);
    load("ld_w_0x40", 32'h40, SZ_W, 1'b0, 32'h0000_0000);
    load("ld_w_0x20", 32'h20, SZ_W, 1'b0, 32'h0000_007F);
    load("ld_w_0x10", 32'h10, SZ_W, 1'b0, 32'h0000_0066);

    // Byte lanes; store data carries junk above the byte.
    store(32'h80, SZ_W, 32'h1234_5678);
    store(32'h81, SZ_B, 32'h1234_56AB);
    load("ld_w_0x80", 32'h80, SZ_W, 1'b0, 32'h1234_AB78);
    load("ld_bs_0x81", 32'h81, SZ_B, 1'b1, 32'hFFFF_FFAB);
    load("ld_bu_0x81", 32'h81, SZ_B, 1'b0, 32'h0000_00AB);
    load("ld_bu_0x83", 32'h83, SZ_B, 1'b0, 32'h0000_0012);
    load("ld_bs_0x80", 32'h80, SZ_B, 1'b1, 32'h0000_0078);
    load("ld_hs_0x80", 32'h80, SZ_H, 1'b1, 32'hFFFF_AB78);

    // Half lanes.
    store(32'h92, SZ_H, 32'hA5A5_8001);
    load("ld_hs_0x92", 32'h92, SZ_H, 1'b1, 32'hFFFF_8001);
    load("ld_hu_0x92", 32'h92, SZ_H, 1'b0, 32'h0000_8001);
    load("ld_w_0x90", 32'h90, SZ_W, 1'b1, 32'h8001_0000);

    // Read and write of the same word in one cycle.
    @(negedge clk);
    set_bus(1'b1, 1'b1, SZ_W, 1'b0, 32'h84, 32'hCAFE_F00D);
    #1 chk("rw_pre_edge", Read_data, 32'h0000_0000);
    @(posedge clk);
    #1 chk("rw_post_edge", Read_data, 32'hCAFE_F00D);
    idle();

    // Faulting accesses leave memory untouched.
    fault_store("f_w_0x82", 32'h82, SZ_W);
    fault_store("f_h_0x85", 32'h85, SZ_H);
    fault_store("f_b_0x400", 32'h400, SZ_B);
    fault_store("f_r_0x80", 32'h80, SZ_R);
    load("keep_0x80", 32'h80, SZ_W, 1'b0, 32'h1234_AB78);
    load("keep_0x84", 32'h84, SZ_W, 1'b0, 32'hCAFE_F00D);
    load("keep_0x00", 32'h00, SZ_W, 1'b0, 32'h0000_003F);

    // Restart: reset from READY, then again 100 edges into the sweep.
    store(32'hA0, SZ_W, 32'h0000_0055);
    load("ld_w_0xA0", 32'hA0, SZ_W, 1'b0, 32'h0000_0055);
    @(negedge clk);
    reset = 1'b1;
    set_bus(1'b1, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
    #1;
    chk("ready_rst_busy", {31'h0, Busy}, 32'h1);
    chk("ready_rst_rdata", Read_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("mid_rst_busy", {31'h0, Busy}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    idle();
    sweep(1'b0, n_edges);
    chk("resweep_len", n_edges, 32'd256);
    load("clr_0xA0", 32'hA0, SZ_W, 1'b0, 32'h0000_0000);
    load("reinit_0x3C", 32'h3C, SZ_W, 1'b0, 32'h0000_0071);

    if (exp_q.size() != 0) begin
      n_err++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
